// File: rtl/slowclk_scheduler.sv
// Slow-clock divider controller: tick enable, toggling slowclk, start/stop/burst, handshaked divisor reload.
// Optional SLOWCLK_TICK_COUNT_EN adds a free-running 16-bit tick_count output.
module slowclk_scheduler #(
  parameter int               WIDTH        = 23,
  parameter logic [WIDTH-1:0] DEFAULT_TERM = {WIDTH{1'b1}}
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             cmd_burst,
  input  logic [7:0]       burst_len,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_term,
  output logic             cfg_ready,
  output logic             tick,
  output logic             slowclk,
  output logic             running,
`ifdef SLOWCLK_TICK_COUNT_EN
  output logic [15:0]      tick_count,
`endif
  output logic [7:0]       burst_left
);

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_BURST} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic [WIDTH-1:0] active_term, pending_term;
  logic             pending;
  logic             tick_nxt, slowclk_nxt;
  logic [7:0]       burst_left_nxt;
  logic             wrap, accept, apply;

  assign cfg_ready = !pending;

  always_comb begin
    wrap           = (state != ST_STOP) && (count == active_term);
    accept         = cfg_valid && !pending;
    // A new term only lands at a wrap or while idle, so an interval is never cut short.
    apply          = pending && ((state == ST_STOP) || wrap);
    state_nxt      = state;
    count_nxt      = count;
    tick_nxt       = 1'b0;
    slowclk_nxt    = slowclk;
    burst_left_nxt = burst_left;
    case (state)
      ST_STOP: begin
        count_nxt   = '0;
        slowclk_nxt = 1'b0;
        if (cmd_stop) begin
          state_nxt = ST_STOP;
        end else if (cmd_start) begin
          state_nxt = ST_RUN;
        end else if (cmd_burst && (burst_len != 8'd0)) begin
          state_nxt      = ST_BURST;
          burst_left_nxt = burst_len;
        end
      end
      default: begin
        count_nxt   = wrap ? '0 : count + 1'b1;
        tick_nxt    = wrap;
        slowclk_nxt = slowclk ^ wrap;
        if (state == ST_BURST) begin
          if (wrap) begin
            burst_left_nxt = burst_left - 8'd1;
            if (burst_left == 8'd1) state_nxt = ST_STOP;
          end
          if (cmd_start) begin
            state_nxt      = ST_RUN;
            burst_left_nxt = 8'd0;
          end
        end
        if (cmd_stop) begin
          state_nxt      = ST_STOP;
          count_nxt      = '0;
          tick_nxt       = 1'b0;
          slowclk_nxt    = 1'b0;
          burst_left_nxt = 8'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_STOP;
      count       <= '0;
      active_term <= DEFAULT_TERM;
      pending     <= 1'b0;
      tick        <= 1'b0;
      slowclk     <= 1'b0;
      running     <= 1'b0;
      burst_left  <= 8'd0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      tick       <= tick_nxt;
      slowclk    <= slowclk_nxt;
      running    <= (state_nxt != ST_STOP);
      burst_left <= burst_left_nxt;
      if (apply) begin
        active_term <= pending_term;
        pending     <= 1'b0;
      end else if (accept) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) pending_term <= cfg_term;
  end

`ifdef SLOWCLK_TICK_COUNT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) tick_count <= 16'd0;
    else         tick_count <= tick_count + {15'd0, tick};
  end
`endif

endmodule

// File: tb/tb_slowclk_scheduler.sv
// Directed bench for slowclk_scheduler with DEFAULT_TERM overridden to 3.
module tb_slowclk_scheduler;

  localparam int WIDTH = 23;

  logic             clock;
  logic             resetn;
  logic             cmd_start, cmd_stop, cmd_burst;
  logic [7:0]       burst_len;
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_term;
  logic             cfg_ready, tick, slowclk, running;
  logic [7:0]       burst_left;
`ifdef SLOWCLK_TICK_COUNT_EN
  logic [15:0]      tick_count;
`endif

  int passed = 0;
  int total  = 0;

  slowclk_scheduler #(.WIDTH(WIDTH), .DEFAULT_TERM(23'd3)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .cmd_start  (cmd_start),
    .cmd_stop   (cmd_stop),
    .cmd_burst  (cmd_burst),
    .burst_len  (burst_len),
    .cfg_valid  (cfg_valid),
    .cfg_term   (cfg_term),
    .cfg_ready  (cfg_ready),
    .tick       (tick),
    .slowclk    (slowclk),
    .running    (running),
`ifdef SLOWCLK_TICK_COUNT_EN
    .tick_count (tick_count),
`endif
    .burst_left (burst_left)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic test_reset();
    resetn = 1'b0; cmd_start = 0; cmd_stop = 0; cmd_burst = 0;
    burst_len = 0; cfg_valid = 0; cfg_term = '0;
    #12;
    total++; if (tick !== 1'b0) $display("FAIL reset_tick got %b want 0", tick); else passed++;
    total++; if (slowclk !== 1'b0) $display("FAIL reset_slowclk got %b want 0", slowclk); else passed++;
    total++; if (running !== 1'b0) $display("FAIL reset_running got %b want 0", running); else passed++;
    total++; if (burst_left !== 8'd0) $display("FAIL reset_burst_left got %0d want 0", burst_left); else passed++;
    total++; if (cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); else passed++;
    @(negedge clock); resetn = 1'b1;
  endtask

  task automatic test_run();
    logic et, es;
    @(negedge clock); cmd_start = 1;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clock); cmd_start = 0;
      et = (i == 4) || (i == 8) || (i == 12);
      es = ((i >= 4) && (i < 8)) || (i == 12);
      total++; if (tick !== et) $display("FAIL run_tick i=%0d got %b want %b", i, tick, et); else passed++;
      total++; if (slowclk !== es) $display("FAIL run_slowclk i=%0d got %b want %b", i, slowclk, es); else passed++;
      total++; if (running !== 1'b1) $display("FAIL run_running i=%0d got %b want 1", i, running); else passed++;
    end
    cmd_stop = 1;
    @(negedge clock); cmd_stop = 0;
    total++; if (running !== 1'b0) $display("FAIL run_stop_running got %b want 0", running); else passed++;
    total++; if (slowclk !== 1'b0) $display("FAIL run_stop_slowclk got %b want 0", slowclk); else passed++;
  endtask

  task automatic test_burst();
    logic et, es, er;
    logic [7:0] eb;
    @(negedge clock); burst_len = 8'd3; cmd_burst = 1;
    for (int i = 0; i <= 15; i++) begin
      @(negedge clock); cmd_burst = 0;
      et = (i == 4) || (i == 8) || (i == 12);
      es = ((i >= 4) && (i < 8)) || (i == 12);
      er = (i < 12);
      eb = (i < 4) ? 8'd3 : (i < 8) ? 8'd2 : (i < 12) ? 8'd1 : 8'd0;
      total++; if (tick !== et) $display("FAIL burst_tick i=%0d got %b want %b", i, tick, et); else passed++;
      total++; if (slowclk !== es) $display("FAIL burst_slowclk i=%0d got %b want %b", i, slowclk, es); else passed++;
      total++; if (running !== er) $display("FAIL burst_running i=%0d got %b want %b", i, running, er); else passed++;
      total++; if (burst_left !== eb) $display("FAIL burst_left i=%0d got %0d want %0d", i, burst_left, eb); else passed++;
    end
    burst_len = 8'd0; cmd_burst = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock); cmd_burst = 0;
      total++; if (tick !== 1'b0) $display("FAIL burst0_tick i=%0d got %b want 0", i, tick); else passed++;
      total++; if (running !== 1'b0) $display("FAIL burst0_running i=%0d got %b want 0", i, running); else passed++;
    end
  endtask

  task automatic test_reconfig();
    logic et, es, ec;
    @(negedge clock); cmd_start = 1;
    for (int i = 0; i <= 9; i++) begin
      @(negedge clock); cmd_start = 0;
      et = (i == 4) || (i == 6) || (i == 8);
      es = ((i >= 4) && (i < 6)) || (i >= 8);
      ec = !((i == 2) || (i == 3));
      total++; if (tick !== et) $display("FAIL cfg_tick i=%0d got %b want %b", i, tick, et); else passed++;
      total++; if (slowclk !== es) $display("FAIL cfg_slowclk i=%0d got %b want %b", i, slowclk, es); else passed++;
      total++; if (cfg_ready !== ec) $display("FAIL cfg_ready i=%0d got %b want %b", i, cfg_ready, ec); else passed++;
      if (i == 1) begin cfg_valid = 1; cfg_term = 23'd1; end
      if (i == 2) cfg_term = 23'd2;
      if (i == 3) cfg_valid = 0;
      if (i == 9) cmd_stop = 1;
    end
  endtask

  task automatic test_stop_at_wrap();
    logic et;
    @(negedge clock); cmd_stop = 0;
    total++; if (tick !== 1'b0) $display("FAIL stopwrap_tick got %b want 0", tick); else passed++;
    total++; if (running !== 1'b0) $display("FAIL stopwrap_running got %b want 0", running); else passed++;
    total++; if (slowclk !== 1'b0) $display("FAIL stopwrap_slowclk got %b want 0", slowclk); else passed++;
    cmd_start = 1; cmd_stop = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); cmd_start = 0; cmd_stop = 0;
      total++; if (running !== 1'b0) $display("FAIL startstop_running i=%0d got %b want 0", i, running); else passed++;
      total++; if (tick !== 1'b0) $display("FAIL startstop_tick i=%0d got %b want 0", i, tick); else passed++;
    end
    cmd_start = 1;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clock); cmd_start = 0;
      et = (i == 2) || (i == 4);
      total++; if (tick !== et) $display("FAIL restart_tick i=%0d got %b want %b", i, tick, et); else passed++;
    end
    cmd_stop = 1;
    @(negedge clock); cmd_stop = 0;
  endtask

  task automatic test_async_reset();
    logic et;
    @(negedge clock); burst_len = 8'd5; cmd_burst = 1;
    @(negedge clock); cmd_burst = 0;
    total++; if (burst_left !== 8'd5) $display("FAIL ar_burst_left0 got %0d want 5", burst_left); else passed++;
    @(negedge clock); cfg_valid = 1; cfg_term = 23'd5;
    @(negedge clock); cfg_valid = 0;
    total++; if (tick !== 1'b1) $display("FAIL ar_pre_tick got %b want 1", tick); else passed++;
    total++; if (cfg_ready !== 1'b0) $display("FAIL ar_pre_cfg_ready got %b want 0", cfg_ready); else passed++;
    total++; if (burst_left !== 8'd4) $display("FAIL ar_pre_burst_left got %0d want 4", burst_left); else passed++;
    #2 resetn = 1'b0;
    #1;
    total++; if (tick !== 1'b0) $display("FAIL ar_tick got %b want 0", tick); else passed++;
    total++; if (slowclk !== 1'b0) $display("FAIL ar_slowclk got %b want 0", slowclk); else passed++;
    total++; if (running !== 1'b0) $display("FAIL ar_running got %b want 0", running); else passed++;
    total++; if (burst_left !== 8'd0) $display("FAIL ar_burst_left got %0d want 0", burst_left); else passed++;
    total++; if (cfg_ready !== 1'b1) $display("FAIL ar_cfg_ready got %b want 1", cfg_ready); else passed++;
    @(negedge clock); resetn = 1'b1; cmd_start = 1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clock); cmd_start = 0;
      et = (i == 4) || (i == 8);
      total++; if (tick !== et) $display("FAIL ar_term_tick i=%0d got %b want %b", i, tick, et); else passed++;
    end
    cmd_stop = 1;
    @(negedge clock); cmd_stop = 0;
  endtask

  task automatic test_term_zero();
    logic et, es;
    @(negedge clock); cfg_valid = 1; cfg_term = 23'd0;
    @(negedge clock); cfg_valid = 0;
    total++; if (cfg_ready !== 1'b0) $display("FAIL tz_cfg_ready_low got %b want 0", cfg_ready); else passed++;
    @(negedge clock);
    total++; if (cfg_ready !== 1'b1) $display("FAIL tz_cfg_ready_high got %b want 1", cfg_ready); else passed++;
    cmd_start = 1;
    for (int j = 0; j <= 7; j++) begin
      @(negedge clock); cmd_start = 0;
      et = (j >= 1);
      es = (j % 2) == 1;
      total++; if (tick !== et) $display("FAIL tz_tick j=%0d got %b want %b", j, tick, et); else passed++;
      total++; if (slowclk !== es) $display("FAIL tz_slowclk j=%0d got %b want %b", j, slowclk, es); else passed++;
`ifdef SLOWCLK_TICK_COUNT_EN
      if (j == 7) begin
        total++; if (tick_count !== 16'd8) $display("FAIL tz_tick_count got %0d want 8", tick_count); else passed++;
      end
`endif
    end
`ifdef SLOWCLK_TICK_COUNT_EN
    begin
      int n;
      n = 0;
      while ((tick_count !== 16'hFFFF) && (n < 70000)) begin
        @(negedge clock); n++;
      end
      total++; if (tick_count !== 16'hFFFF) $display("FAIL tc_reach_max got %h want ffff", tick_count); else passed++;
      @(negedge clock);
      total++; if (tick_count !== 16'h0000) $display("FAIL tc_wrap got %h want 0000", tick_count); else passed++;
    end
`endif
    cmd_stop = 1;
    @(negedge clock); cmd_stop = 0;
    total++; if (running !== 1'b0) $display("FAIL tz_stop_running got %b want 0", running); else passed++;
  endtask

  initial begin
    test_reset();
    test_run();
    test_burst();
    test_reconfig();
    test_stop_at_wrap();
    test_async_reset();
    test_term_zero();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
